// File: rtl/chess_pkg.sv
// Shared definitions for the move sequencer and the move verifier.
//   piece_e       : bitboard index of each piece type (black 0-5, white 6-11)
//   INIT_BOARDS   : standard starting position, board k in bits [64k+63:64k]
//   state_e       : cursor/selection state machine encoding
//   square_index  : (file, rank) -> bit index 8*rank + file
package chess_pkg;

    typedef enum logic [3:0] {
        BP   = 4'd0,
        BN   = 4'd1,
        BB   = 4'd2,
        BR   = 4'd3,
        BQ   = 4'd4,
        BK   = 4'd5,
        WP   = 4'd6,
        WN   = 4'd7,
        WB   = 4'd8,
        WR   = 4'd9,
        WQ   = 4'd10,
        WK   = 4'd11,
        NONE = 4'd13
    } piece_e;

    // Concatenated from board 11 (white king) down to board 0 (black pawns).
    localparam logic [767:0] INIT_BOARDS = {
        64'h0000_0000_0000_0010,   // WK e1
        64'h0000_0000_0000_0008,   // WQ d1
        64'h0000_0000_0000_0081,   // WR a1 h1
        64'h0000_0000_0000_0024,   // WB c1 f1
        64'h0000_0000_0000_0042,   // WN b1 g1
        64'h0000_0000_0000_FF00,   // WP rank 1
        64'h1000_0000_0000_0000,   // BK e8
        64'h0800_0000_0000_0000,   // BQ d8
        64'h8100_0000_0000_0000,   // BR a8 h8
        64'h2400_0000_0000_0000,   // BB c8 f8
        64'h4200_0000_0000_0000,   // BN b8 g8
        64'h00FF_0000_0000_0000    // BP rank 6
    };

    typedef enum logic [1:0] {
        PICK_SRC = 2'd0,
        PICK_DST = 2'd1,
        EVAL     = 2'd2,
        REJECT   = 2'd3
    } state_e;

    function automatic logic [5:0] square_index(input logic [2:0] file, input logic [2:0] rank);
        return {rank, file};
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Display cursor: saturating 3-bit file/rank counters.
//   clk, rst_n            : clock, async active-low reset (cursor -> (4,1))
//   enable                : direction buttons are honoured only when high
//   btn_up/down/left/right: single-cycle direction pulses
//   btn_select/btn_cancel : higher-priority pulses; suppress any move this cycle
//   cursor_file/rank      : current cursor position
module cursor_ctrl
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_select,
    input  logic       btn_cancel,
    output logic [2:0] cursor_file,
    output logic [2:0] cursor_rank
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_file <= 3'd4;
            cursor_rank <= 3'd1;
        end else if (enable && !btn_cancel && !btn_select) begin
            // One action per cycle: up > down > left > right.
            if (btn_up) begin
                if (cursor_rank != 3'd7) cursor_rank <= cursor_rank + 3'd1;
            end else if (btn_down) begin
                if (cursor_rank != 3'd0) cursor_rank <= cursor_rank - 3'd1;
            end else if (btn_left) begin
                if (cursor_file != 3'd0) cursor_file <= cursor_file - 3'd1;
            end else if (btn_right) begin
                if (cursor_file != 3'd7) cursor_file <= cursor_file + 3'd1;
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Sequential front end of the move verifier: holds the committed game state
// and runs the cursor/selection state machine.
//   clk, rst_n                    : clock, async active-low reset
//   btn_*                         : debounced single-cycle button pulses
//   vfy_move_is_valid/new_boards/potential_ep : verifier results for the candidate
//   old_/new_file/rank            : candidate move presented to the verifier
//   is_white, piece_boards, en_passant_bitboard, half_moves : committed state
//   cursor_file/rank              : display cursor
//   src_selected, reject_flash    : UI indications
//
// state    | meaning
// PICK_SRC | cursor roams, select on an own piece latches the source
// PICK_DST | source held, select latches the destination
// EVAL     | one cycle; verifier result committed or rejected at its end
// REJECT   | reject_flash held for REJECT_CYCLES, then back to PICK_DST
module move_sequencer
    import chess_pkg::*;
#(
    parameter int REJECT_CYCLES = 25_000_000,
    parameter int CNT_W         = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_select,
    input  logic         btn_cancel,
    input  logic         vfy_move_is_valid,
    input  logic [767:0] vfy_new_boards,
    input  logic [63:0]  vfy_potential_ep,
    output logic [2:0]   old_file,
    output logic [2:0]   old_rank,
    output logic [2:0]   new_file,
    output logic [2:0]   new_rank,
    output logic         is_white,
    output logic [767:0] piece_boards,
    output logic [63:0]  en_passant_bitboard,
    output logic [2:0]   cursor_file,
    output logic [2:0]   cursor_rank,
    output logic         src_selected,
    output logic         reject_flash,
    output logic [9:0]   half_moves
);

    localparam logic [CNT_W-1:0] REJECT_LAST = CNT_W'(REJECT_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] reject_cnt;
    logic [63:0]      occ_white;
    logic [63:0]      occ_black;
    logic             own_piece;
    logic             cursor_enable;

    always_comb begin
        occ_white = '0;
        occ_black = '0;
        for (int k = 0; k < 6; k++) begin
            occ_black = occ_black | piece_boards[64*(k + int'(BP)) +: 64];
            occ_white = occ_white | piece_boards[64*(k + int'(WP)) +: 64];
        end
    end

    assign own_piece = is_white ? occ_white[square_index(cursor_file, cursor_rank)]
                                : occ_black[square_index(cursor_file, cursor_rank)];

    assign cursor_enable = (state == PICK_SRC) || (state == PICK_DST);
    assign src_selected  = (state != PICK_SRC);

    cursor_ctrl u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (cursor_enable),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_select  (btn_select),
        .btn_cancel  (btn_cancel),
        .cursor_file (cursor_file),
        .cursor_rank (cursor_rank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= PICK_SRC;
            piece_boards        <= INIT_BOARDS;
            en_passant_bitboard <= '0;
            is_white            <= 1'b1;
            half_moves          <= '0;
            old_file            <= '0;
            old_rank            <= '0;
            new_file            <= '0;
            new_rank            <= '0;
            reject_flash        <= 1'b0;
            reject_cnt          <= '0;
        end else begin
            case (state)
                PICK_SRC: begin
                    if (!btn_cancel && btn_select && own_piece) begin
                        old_file <= cursor_file;
                        old_rank <= cursor_rank;
                        state    <= PICK_DST;
                    end
                end
                PICK_DST: begin
                    if (btn_cancel) begin
                        state <= PICK_SRC;
                    end else if (btn_select) begin
                        new_file <= cursor_file;
                        new_rank <= cursor_rank;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (vfy_move_is_valid) begin
                        piece_boards        <= vfy_new_boards;
                        en_passant_bitboard <= vfy_potential_ep;
                        is_white            <= ~is_white;
                        if (half_moves != 10'h3FF) half_moves <= half_moves + 10'd1;
                        state               <= PICK_SRC;
                    end else begin
                        reject_cnt   <= '0;
                        reject_flash <= 1'b1;
                        state        <= REJECT;
                    end
                end
                REJECT: begin
                    // Count values 0..REJECT_CYCLES-1 give exactly REJECT_CYCLES flash cycles.
                    if (btn_cancel) begin
                        reject_flash <= 1'b0;
                        state        <= PICK_SRC;
                    end else if (reject_cnt == REJECT_LAST) begin
                        reject_flash <= 1'b0;
                        state        <= PICK_DST;
                    end else begin
                        reject_cnt <= reject_cnt + 1'b1;
                    end
                end
                default: state <= PICK_SRC;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

    localparam int RC = 4;

    localparam logic [5:0] C = 6'b100000;
    localparam logic [5:0] S = 6'b010000;
    localparam logic [5:0] U = 6'b001000;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] R = 6'b000001;
    localparam logic [5:0] N = 6'b000000;

    localparam logic [767:0] EXP_INIT = {
        64'h0000_0000_0000_0010, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0081,
        64'h0000_0000_0000_0024, 64'h0000_0000_0000_0042, 64'h0000_0000_0000_FF00,
        64'h1000_0000_0000_0000, 64'h0800_0000_0000_0000, 64'h8100_0000_0000_0000,
        64'h2400_0000_0000_0000, 64'h4200_0000_0000_0000, 64'h00FF_0000_0000_0000
    };

    logic         clk;
    logic         rst_n;
    logic         btn_up, btn_down, btn_left, btn_right, btn_select, btn_cancel;
    logic         vfy_move_is_valid;
    logic [767:0] vfy_new_boards;
    logic [63:0]  vfy_potential_ep;
    logic [2:0]   old_file, old_rank, new_file, new_rank;
    logic         is_white;
    logic [767:0] piece_boards;
    logic [63:0]  en_passant_bitboard;
    logic [2:0]   cursor_file, cursor_rank;
    logic         src_selected;
    logic         reject_flash;
    logic [9:0]   half_moves;

    logic [767:0] exp_e4;
    logic [63:0]  exp_ep;

    int checks;
    int failures;

    typedef struct {
        logic [5:0] btn;
        logic       vld;
        logic [2:0] cf, cr;
        logic       src;
        logic [2:0] ofl, orn, nf, nr;
        logic       wh;
        logic [9:0] hm;
    } vec_t;

    vec_t tv[22];

    move_sequencer #(.REJECT_CYCLES(RC), .CNT_W(3)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .btn_up              (btn_up),
        .btn_down            (btn_down),
        .btn_left            (btn_left),
        .btn_right           (btn_right),
        .btn_select          (btn_select),
        .btn_cancel          (btn_cancel),
        .vfy_move_is_valid   (vfy_move_is_valid),
        .vfy_new_boards      (vfy_new_boards),
        .vfy_potential_ep    (vfy_potential_ep),
        .old_file            (old_file),
        .old_rank            (old_rank),
        .new_file            (new_file),
        .new_rank            (new_rank),
        .is_white            (is_white),
        .piece_boards        (piece_boards),
        .en_passant_bitboard (en_passant_bitboard),
        .cursor_file         (cursor_file),
        .cursor_rank         (cursor_rank),
        .src_selected        (src_selected),
        .reject_flash        (reject_flash),
        .half_moves          (half_moves)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] b);
        @(negedge clk);
        {btn_cancel, btn_select, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_cancel, btn_select, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    function automatic vec_t mk(input logic [5:0] b, input int vld, input int cf, input int cr,
                                input int src, input int ofl, input int orn, input int nf,
                                input int nr, input int wh, input int hm);
        vec_t v;
        v.btn = b;
        v.vld = 1'(vld);
        v.cf  = 3'(cf);
        v.cr  = 3'(cr);
        v.src = 1'(src);
        v.ofl = 3'(ofl);
        v.orn = 3'(orn);
        v.nf  = 3'(nf);
        v.nr  = 3'(nr);
        v.wh  = 1'(wh);
        v.hm  = 10'(hm);
        return v;
    endfunction

    task automatic chk_cursor(input string name, input int f, input int r);
        chk({name, " cursor_file"}, 768'(cursor_file), 768'(f));
        chk({name, " cursor_rank"}, 768'(cursor_rank), 768'(r));
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, " boards"}, piece_boards, EXP_INIT);
        chk({name, " ep"}, 768'(en_passant_bitboard), 768'(0));
        chk({name, " is_white"}, 768'(is_white), 768'(1));
        chk({name, " half_moves"}, 768'(half_moves), 768'(0));
        chk_cursor(name, 4, 1);
        chk({name, " old"}, 768'({old_file, old_rank}), 768'(0));
        chk({name, " new"}, 768'({new_file, new_rank}), 768'(0));
        chk({name, " src_selected"}, 768'(src_selected), 768'(0));
        chk({name, " reject_flash"}, 768'(reject_flash), 768'(0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        {btn_cancel, btn_select, btn_up, btn_down, btn_left, btn_right} = '0;
        vfy_move_is_valid = 1'b0;
        exp_e4 = EXP_INIT;
        exp_e4[6*64 +: 64] = 64'h0000_0000_1000_EF00;
        exp_ep = 64'h0000_0000_0010_0000;
        vfy_new_boards   = exp_e4;
        vfy_potential_ep = exp_ep;

        //            btn    vld cf cr src of or nf nr wh hm
        tv[0]  = mk(U,     0, 4, 2, 0, 0, 0, 0, 0, 1, 0);
        tv[1]  = mk(U,     0, 4, 3, 0, 0, 0, 0, 0, 1, 0);
        tv[2]  = mk(S,     0, 4, 3, 0, 0, 0, 0, 0, 1, 0);
        tv[3]  = mk(C,     0, 4, 3, 0, 0, 0, 0, 0, 1, 0);
        tv[4]  = mk(U,     0, 4, 4, 0, 0, 0, 0, 0, 1, 0);
        tv[5]  = mk(U,     0, 4, 5, 0, 0, 0, 0, 0, 1, 0);
        tv[6]  = mk(U,     0, 4, 6, 0, 0, 0, 0, 0, 1, 0);
        tv[7]  = mk(S,     0, 4, 6, 0, 0, 0, 0, 0, 1, 0);
        tv[8]  = mk(D,     0, 4, 5, 0, 0, 0, 0, 0, 1, 0);
        tv[9]  = mk(D,     0, 4, 4, 0, 0, 0, 0, 0, 1, 0);
        tv[10] = mk(D,     0, 4, 3, 0, 0, 0, 0, 0, 1, 0);
        tv[11] = mk(D,     0, 4, 2, 0, 0, 0, 0, 0, 1, 0);
        tv[12] = mk(D,     0, 4, 1, 0, 0, 0, 0, 0, 1, 0);
        tv[13] = mk(S | U, 0, 4, 1, 1, 4, 1, 0, 0, 1, 0);
        tv[14] = mk(C,     0, 4, 1, 0, 4, 1, 0, 0, 1, 0);
        tv[15] = mk(L,     0, 3, 1, 0, 4, 1, 0, 0, 1, 0);
        tv[16] = mk(R,     0, 4, 1, 0, 4, 1, 0, 0, 1, 0);
        tv[17] = mk(S,     0, 4, 1, 1, 4, 1, 0, 0, 1, 0);
        tv[18] = mk(U,     0, 4, 2, 1, 4, 1, 0, 0, 1, 0);
        tv[19] = mk(U,     0, 4, 3, 1, 4, 1, 0, 0, 1, 0);
        tv[20] = mk(S,     0, 4, 3, 1, 4, 1, 4, 3, 1, 0);
        tv[21] = mk(N,     1, 4, 3, 0, 4, 1, 4, 3, 0, 1);

        rst_n = 1'b0;
        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            vfy_move_is_valid = tv[i].vld;
            step(tv[i].btn);
            chk_cursor(tag, int'(tv[i].cf), int'(tv[i].cr));
            chk({tag, " src_selected"}, 768'(src_selected), 768'(tv[i].src));
            chk({tag, " reject_flash"}, 768'(reject_flash), 768'(0));
            chk({tag, " old"}, 768'({old_file, old_rank}), 768'({tv[i].ofl, tv[i].orn}));
            chk({tag, " new"}, 768'({new_file, new_rank}), 768'({tv[i].nf, tv[i].nr}));
            chk({tag, " is_white"}, 768'(is_white), 768'(tv[i].wh));
            chk({tag, " half_moves"}, 768'(half_moves), 768'(tv[i].hm));
        end
        vfy_move_is_valid = 1'b0;

        // e2-e4 committed
        chk("e4 boards", piece_boards, exp_e4);
        chk("e4 wp bit12", 768'(piece_boards[6*64 + 12]), 768'(0));
        chk("e4 wp bit28", 768'(piece_boards[6*64 + 28]), 768'(1));
        chk("e4 ep", 768'(en_passant_bitboard), 768'(exp_ep));

        // Black selects e7, targets e8: verifier says illegal
        vfy_new_boards   = EXP_INIT;
        vfy_potential_ep = 64'hFFFF_0000_0000_0000;
        step(U); step(U); step(U);
        chk_cursor("blk up", 4, 6);
        step(S);
        chk("blk src", 768'(src_selected), 768'(1));
        chk("blk old", 768'({old_file, old_rank}), 768'({3'd4, 3'd6}));
        step(U);
        step(S);
        chk("eval new", 768'({new_file, new_rank}), 768'({3'd4, 3'd7}));
        chk("eval flash", 768'(reject_flash), 768'(0));
        for (int i = 0; i < RC; i++) begin
            step(i == 1 ? (S | U) : N);
            chk($sformatf("reject flash %0d", i), 768'(reject_flash), 768'(1));
            chk($sformatf("reject src %0d", i), 768'(src_selected), 768'(1));
            chk_cursor($sformatf("reject cursor %0d", i), 4, 7);
        end
        step(N);
        chk("reject end flash", 768'(reject_flash), 768'(0));
        chk("reject end src", 768'(src_selected), 768'(1));
        chk("reject end old", 768'({old_file, old_rank}), 768'({3'd4, 3'd6}));
        chk("reject end boards", piece_boards, exp_e4);
        chk("reject end ep", 768'(en_passant_bitboard), 768'(exp_ep));
        chk("reject end is_white", 768'(is_white), 768'(0));
        chk("reject end half", 768'(half_moves), 768'(1));
        step(U);
        chk_cursor("pick_dst again up", 4, 7);

        // Cancel aborts a second reject
        step(S);
        step(N);
        chk("reject2 flash", 768'(reject_flash), 768'(1));
        step(C);
        chk("cancel flash", 768'(reject_flash), 768'(0));
        chk("cancel src", 768'(src_selected), 768'(0));

        // Saturation at the (7,7) corner
        step(R); step(R); step(R);
        chk_cursor("corner", 7, 7);
        step(U);
        chk_cursor("sat up", 7, 7);
        step(R);
        chk_cursor("sat right", 7, 7);

        // Black rook h8 as source, then asynchronous reset mid-cycle
        step(S);
        chk("h8 src", 768'(src_selected), 768'(1));
        chk("h8 old", 768'({old_file, old_rank}), 768'({3'd7, 3'd7}));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
